// File: rtl/accum_tile_ctrl.sv
// accum_tile_ctrl: sequences one output tile through the 32-bit accumulator
// buffer. It clears the tile region, applies MAC-lane accumulate requests as
// read-modify-write operations, then drains the tile as NUM_LANES-wide beats.
// Optional build macro: ACCUM_TILE_CTRL_PERF_EN adds the perf_acc_cnt_o and
// perf_stall_cnt_o counters and their ports.
module accum_tile_ctrl #(
  parameter int DEPTH      = 8192,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [ADDR_WIDTH:0]             tile_len_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  input  logic                            acc_valid_i,
  output logic                            acc_ready_o,
  input  logic [ADDR_WIDTH-1:0]           acc_offset_i,
  input  logic [DATA_WIDTH-1:0]           acc_data_i,
  input  logic                            acc_last_i,
  output logic                            buf_wr_en_o,
  output logic [ADDR_WIDTH-1:0]           buf_wr_addr_o,
  output logic [DATA_WIDTH-1:0]           buf_wr_data_o,
  output logic                            buf_rmw_en_o,
  output logic [ADDR_WIDTH-1:0]           buf_rmw_addr_o,
  output logic [DATA_WIDTH-1:0]           buf_rmw_data_o,
  output logic                            buf_wide_rd_en_o,
  output logic [ADDR_WIDTH-1:0]           buf_wide_rd_addr_o,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] buf_wide_rd_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data_o,
  output logic                            out_last_o
`ifdef ACCUM_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]                     perf_acc_cnt_o,
  output logic [31:0]                     perf_stall_cnt_o
`endif
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t                          state_reg, state_next;
  logic [ADDR_WIDTH-1:0]           base_reg;
  logic [CW-1:0]                   len_reg;
  logic [CW-1:0]                   cnt_reg;
  logic [CW-1:0]                   ptr_reg;
  logic                            busy_reg, done_reg, err_reg;
  logic                            out_valid_reg, out_last_reg;
  logic [NUM_LANES*DATA_WIDTH-1:0] out_data_reg;

  logic [31:0] len_ext, end_ext;
  logic        start_bad, start_ok;
  logic        acc_hs, in_range, clear_last, issue, final_acc;

  // Start validation: non-empty, whole beats, and fully inside the buffer.
  assign len_ext   = 32'(tile_len_i);
  assign end_ext   = 32'(base_addr_i) + len_ext;
  assign start_bad = (len_ext == 32'd0) ||
                     ((len_ext % 32'(NUM_LANES)) != 32'd0) ||
                     (end_ext > 32'(DEPTH));
  assign start_ok  = (state_reg == IDLE) && start_i && !start_bad;

  assign acc_hs     = acc_valid_i && acc_ready_o;
  assign in_range   = {1'b0, acc_offset_i} < len_reg;
  assign clear_last = cnt_reg == (len_reg - CW'(1));
  // A read is issued only when the single output slot is free or being emptied.
  assign issue      = (state_reg == DRAIN) && !rst_i && (ptr_reg < len_reg) &&
                      (!out_valid_reg || out_ready_i);
  assign final_acc  = (state_reg == DRAIN) && out_valid_reg && out_ready_i && out_last_reg;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = CLEAR;
      CLEAR:   if (clear_last) state_next = ACCUM;
      ACCUM:   if (acc_hs && acc_last_i) state_next = DRAIN;
      DRAIN:   if (final_acc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer-port and request-ready outputs; everything is forced low during reset.
  always_comb begin
    buf_wr_en_o        = 1'b0;
    buf_wr_addr_o      = '0;
    buf_wr_data_o      = '0;
    buf_rmw_en_o       = 1'b0;
    buf_rmw_addr_o     = '0;
    buf_rmw_data_o     = '0;
    buf_wide_rd_en_o   = 1'b0;
    buf_wide_rd_addr_o = '0;
    acc_ready_o        = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        CLEAR: begin
          buf_wr_en_o   = 1'b1;
          buf_wr_addr_o = base_reg + cnt_reg[ADDR_WIDTH-1:0];
        end
        ACCUM: begin
          acc_ready_o = 1'b1;
          if (acc_valid_i && in_range) begin
            buf_rmw_en_o   = 1'b1;
            buf_rmw_addr_o = base_reg + acc_offset_i;
            buf_rmw_data_o = acc_data_i;
          end
        end
        DRAIN: begin
          if (issue) begin
            buf_wide_rd_en_o   = 1'b1;
            buf_wide_rd_addr_o = base_reg + ptr_reg[ADDR_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Tile bookkeeping, status pulses and the one-entry drain output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      done_reg <= final_acc;
      err_reg  <= ((state_reg == IDLE) && start_i && start_bad) || (acc_hs && !in_range);
      busy_reg <= state_next != IDLE;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            base_reg <= base_addr_i;
            len_reg  <= tile_len_i;
            cnt_reg  <= '0;
          end
        end
        CLEAR: cnt_reg <= cnt_reg + CW'(1);
        ACCUM: if (acc_hs && acc_last_i) ptr_reg <= '0;
        DRAIN: begin
          if (issue) begin
            out_data_reg  <= buf_wide_rd_data_i;
            out_valid_reg <= 1'b1;
            out_last_reg  <= ptr_reg == (len_reg - CW'(NUM_LANES));
            ptr_reg       <= ptr_reg + CW'(NUM_LANES);
          end else if (out_valid_reg && out_ready_i) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACCUM_TILE_CTRL_PERF_EN
  logic [31:0] perf_acc_reg, perf_stall_reg;

  // Saturating counters of in-range accumulates and back-pressured drain cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      perf_acc_reg   <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (acc_hs && in_range && (perf_acc_reg != '1))
        perf_acc_reg <= perf_acc_reg + 32'd1;
      if ((state_reg == DRAIN) && out_valid_reg && !out_ready_i && (perf_stall_reg != '1))
        perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_acc_cnt_o   = perf_acc_reg;
  assign perf_stall_cnt_o = perf_stall_reg;
`endif

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign err_o       = err_reg;
  assign out_valid_o = out_valid_reg;
  assign out_last_o  = out_last_reg;
  assign out_data_o  = out_data_reg;

endmodule

// File: tb/tb_accum_tile_ctrl.sv
// tb_accum_tile_ctrl: scoreboard bench for accum_tile_ctrl with a behavioural
// accumulator buffer attached to its write, RMW and wide-read ports.
module tb_accum_tile_ctrl;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NL = 16;
  localparam int BW = NL * DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   tile_len_i = '0;
  logic          busy_o, done_o, err_o;
  logic          acc_valid_i = 1'b0;
  logic          acc_ready_o;
  logic [AW-1:0] acc_offset_i = '0;
  logic [DW-1:0] acc_data_i = '0;
  logic          acc_last_i = 1'b0;
  logic          buf_wr_en_o, buf_rmw_en_o, buf_wide_rd_en_o;
  logic [AW-1:0] buf_wr_addr_o, buf_rmw_addr_o, buf_wide_rd_addr_o;
  logic [DW-1:0] buf_wr_data_o, buf_rmw_data_o;
  logic [BW-1:0] buf_wide_rd_data_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [BW-1:0] out_data_o;
  logic          out_last_o;
`ifdef ACCUM_TILE_CTRL_PERF_EN
  logic [31:0]   perf_acc_cnt_o, perf_stall_cnt_o;
`endif

  accum_tile_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .tile_len_i(tile_len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o), .acc_offset_i(acc_offset_i),
    .acc_data_i(acc_data_i), .acc_last_i(acc_last_i),
    .buf_wr_en_o(buf_wr_en_o), .buf_wr_addr_o(buf_wr_addr_o), .buf_wr_data_o(buf_wr_data_o),
    .buf_rmw_en_o(buf_rmw_en_o), .buf_rmw_addr_o(buf_rmw_addr_o), .buf_rmw_data_o(buf_rmw_data_o),
    .buf_wide_rd_en_o(buf_wide_rd_en_o), .buf_wide_rd_addr_o(buf_wide_rd_addr_o),
    .buf_wide_rd_data_i(buf_wide_rd_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o)
`ifdef ACCUM_TILE_CTRL_PERF_EN
    , .perf_acc_cnt_o(perf_acc_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Behavioural accumulator buffer, pre-filled with garbage so clearing matters.
  logic [DW-1:0] mem [0:8191];
  initial for (int i = 0; i < 8192; i++) mem[i] <= 32'hA5A5_A5A5;
  always @(posedge clk_i) begin
    if (buf_wr_en_o) mem[buf_wr_addr_o] <= buf_wr_data_o;
    if (buf_rmw_en_o) mem[buf_rmw_addr_o] <= mem[buf_rmw_addr_o] + buf_rmw_data_o;
  end
  always_comb begin
    buf_wide_rd_data_i = '0;
    for (int i = 0; i < NL; i++)
      buf_wide_rd_data_i[i*DW +: DW] = mem[buf_wide_rd_addr_o + AW'(i)];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference tile contents and the scoreboard of expected drain beats.
  logic [DW-1:0] exp_tile [0:63];
  logic [BW-1:0] exp_data_q [$];
  logic          exp_last_q [$];
  logic [AW-1:0] cur_base;
  int            cur_len;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_start(input logic [AW-1:0] b, input int l);
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = b; tile_len_i = (AW+1)'(l);
    #1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    cur_base = b; cur_len = l;
    for (int i = 0; i < 64; i++) exp_tile[i] = '0;
  endtask

  task automatic run_clear();
    for (int i = 0; i < cur_len; i++) begin
      n_checks++;
      if (buf_wr_en_o !== 1'b1 || buf_wr_addr_o !== cur_base + AW'(i) || buf_wr_data_o !== '0 || acc_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_write[%0d]: en=%b addr=%h data=%h rdy=%b, expected en=1 addr=%h data=0 rdy=0",
                 i, buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o, acc_ready_o, cur_base + AW'(i));
      end
      @(negedge clk_i); #1;
    end
    n_checks++;
    if (acc_ready_o !== 1'b1 || buf_wr_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_to_accum: acc_ready=%b wr_en=%b, expected 1/0", acc_ready_o, buf_wr_en_o);
    end
    $display("clear base=%h len=%0d complete", cur_base, cur_len);
  endtask

  task automatic send_acc(input int off, input logic [DW-1:0] data, input logic last);
    acc_valid_i = 1'b1; acc_offset_i = AW'(off); acc_data_i = data; acc_last_i = last;
    #1;
    n_checks++;
    if (off < cur_len) begin
      if (acc_ready_o !== 1'b1 || buf_rmw_en_o !== 1'b1 || buf_rmw_addr_o !== cur_base + AW'(off) || buf_rmw_data_o !== data) begin
        n_fail++;
        $display("FAIL acc_rmw off=%0d: rdy=%b en=%b addr=%h data=%h, expected 1/1/%h/%h",
                 off, acc_ready_o, buf_rmw_en_o, buf_rmw_addr_o, buf_rmw_data_o, cur_base + AW'(off), data);
      end
      exp_tile[off] = exp_tile[off] + data;
    end else if (acc_ready_o !== 1'b1 || buf_rmw_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL acc_oob off=%0d: rdy=%b rmw_en=%b, expected 1/0", off, acc_ready_o, buf_rmw_en_o);
    end
    $display("acc off=%0d data=%h last=%b", off, data, last);
    if (last) begin
      for (int b = 0; b < cur_len / NL; b++) begin
        logic [BW-1:0] beat;
        for (int l = 0; l < NL; l++) beat[l*DW +: DW] = exp_tile[b*NL + l];
        exp_data_q.push_back(beat);
        exp_last_q.push_back(b == cur_len / NL - 1);
      end
    end
    @(negedge clk_i);
    acc_valid_i = 1'b0; acc_last_i = 1'b0;
    #1;
  endtask

  task automatic drain_collect(input int n_beats);
    int  beats = 0;
    int  first_c = -1;
    int  last_c = -1;
    bit  fin = 0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 60 && !fin; c++) begin
      if (out_valid_o && out_ready_i) begin
        logic [BW-1:0] ed;
        logic          el;
        if (exp_data_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL drain_extra_beat: beat %0d with empty scoreboard", beats);
          ed = '0; el = 1'b0;
        end else begin
          ed = exp_data_q.pop_front(); el = exp_last_q.pop_front();
        end
        n_checks++;
        if (out_data_o !== ed || out_last_o !== el) begin
          n_fail++;
          $display("FAIL drain_beat[%0d]: data=%h last=%b, expected data=%h last=%b", beats, out_data_o, out_last_o, ed, el);
        end
        $display("drain beat %0d last=%b lane0=%h", beats, out_last_o, out_data_o[DW-1:0]);
        if (first_c < 0) first_c = c;
        last_c = c;
        beats++;
        if (out_last_o) begin
          fin = 1;
          @(negedge clk_i); #1;
          n_checks++;
          if (done_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_done: done=%b busy=%b valid=%b, expected 1/0/0", done_o, busy_o, out_valid_o);
          end
          @(negedge clk_i); #1;
          n_checks++;
          if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b, expected 0", done_o);
          end
        end
      end
      if (!fin) begin
        @(negedge clk_i); #1;
      end
    end
    n_checks++;
    if (!fin || beats != n_beats || (last_c - first_c) != n_beats - 1 || exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_count: beats=%0d span=%0d finished=%0d left=%0d, expected beats=%0d span=%0d",
               beats, last_c - first_c, fin, exp_data_q.size(), n_beats, n_beats - 1);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      n_checks++;
      if (buf_wr_en_o !== 1'b0 || buf_rmw_en_o !== 1'b0 || buf_wide_rd_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_enables: wr=%b rmw=%b rd=%b, expected 0", buf_wr_en_o, buf_rmw_en_o, buf_wide_rd_en_o);
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, err_o, acc_ready_o, out_valid_o, out_last_o} !== 6'b0 || out_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b err=%b rdy=%b valid=%b last=%b, expected all 0",
               busy_o, done_o, err_o, acc_ready_o, out_valid_o, out_last_o);
    end
  endtask

  task automatic test_clear_accum_drain();
    do_start(13'h100, 32);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: busy=%b, expected 1", busy_o);
    end
    run_clear();
    send_acc(5, 32'd1, 1'b0);
    send_acc(5, 32'd2, 1'b0);
    send_acc(5, 32'd3, 1'b1);
    n_checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL accum_no_err: err=%b busy=%b, expected 0/1", err_o, busy_o);
    end
    drain_collect(2);
  endtask

  task automatic test_reject();
    logic [AW-1:0] bases [2] = '{13'h000, 13'd8180};
    int            lens  [2] = '{24, 32};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      start_i = 1'b1; base_addr_i = bases[k]; tile_len_i = (AW+1)'(lens[k]);
      #1;
      @(negedge clk_i);
      start_i = 1'b0;
      #1;
      n_checks++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || buf_wr_en_o !== 1'b0 || buf_rmw_en_o !== 1'b0 || buf_wide_rd_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reject[%0d]: err=%b busy=%b wr=%b rmw=%b rd=%b, expected 1/0/0/0/0",
                 k, err_o, busy_o, buf_wr_en_o, buf_rmw_en_o, buf_wide_rd_en_o);
      end
      @(negedge clk_i); #1;
      n_checks++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || buf_wr_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reject_after[%0d]: err=%b busy=%b wr=%b, expected 0/0/0", k, err_o, busy_o, buf_wr_en_o);
      end
      $display("start base=%0d len=%0d rejected", bases[k], lens[k]);
    end
  endtask

  task automatic test_bad_offset();
    do_start(13'h000, 32);
    run_clear();
    send_acc(7, 32'h0000_0011, 1'b0);
    send_acc(40, 32'h0000_0055, 1'b1);
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_offset_err: err=%b, expected 1", err_o);
    end
    drain_collect(2);
  endtask

  task automatic test_stall();
    logic [BW-1:0] held;
    do_start(13'h200, 48);
    run_clear();
    out_ready_i = 1'b0;
    send_acc(3, 32'd7, 1'b0);
    send_acc(20, 32'd5, 1'b1);
    @(negedge clk_i); #1;
    held = out_data_o;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== held || out_last_o !== 1'b0 || buf_wide_rd_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b last=%b rd_en=%b changed=%b, expected 1/0/0/0",
                 s, out_valid_o, out_last_o, buf_wide_rd_en_o, out_data_o !== held);
      end
      @(negedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    drain_collect(3);
`ifdef ACCUM_TILE_CTRL_PERF_EN
    n_checks++;
    if (perf_stall_cnt_o !== 32'd3 || perf_acc_cnt_o !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_counters: stall=%0d acc=%0d, expected 3/2", perf_stall_cnt_o, perf_acc_cnt_o);
    end
`endif
  endtask

  task automatic test_reset_in_drain();
    do_start(13'h300, 32);
    run_clear();
    out_ready_i = 1'b0;
    send_acc(0, 32'd9, 1'b1);
    @(negedge clk_i); #1;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (buf_wr_en_o !== 1'b0 || buf_rmw_en_o !== 1'b0 || buf_wide_rd_en_o !== 1'b0 || acc_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain_enables: wr=%b rmw=%b rd=%b rdy=%b, expected 0",
               buf_wr_en_o, buf_rmw_en_o, buf_wide_rd_en_o, acc_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    exp_data_q.delete(); exp_last_q.delete();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({busy_o, done_o, err_o, out_valid_o, out_last_o} !== 5'b0 || out_data_o !== '0 || buf_wide_rd_en_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_drain_state[%0d]: busy=%b done=%b err=%b valid=%b last=%b rd=%b, expected all 0",
                 c, busy_o, done_o, err_o, out_valid_o, out_last_o, buf_wide_rd_en_o);
      end
      @(negedge clk_i);
    end
    #1;
    do_start(13'h040, 16);
    run_clear();
    send_acc(15, 32'hDEAD_BEEF, 1'b1);
    drain_collect(1);
  endtask

  initial begin
    test_reset();
    test_clear_accum_drain();
    test_reject();
    test_bad_offset();
    test_stall();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_tile_ctrl.md
Name: accum_tile_ctrl

Overview:
- Sequences one output tile through the 32-bit accumulator buffer.
- Phase order: clear the tile region, accept MAC-lane accumulate requests as read-modify-write operations, then drain the tile as NUM_LANES-wide beats on a valid/ready stream.
- Sits between the MAC array and the accumulator buffer, and is the only driver of the buffer's write, RMW and wide-read ports.

Parameters:
- DEPTH, 8192, buffer depth in words.
- ADDR_WIDTH, 13, buffer address width.
- DATA_WIDTH, 32, accumulator word width.
- NUM_LANES, 16, words per drain beat.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  start-tile pulse.
- base_addr_i  in  ADDR_WIDTH  tile base word address.
- tile_len_i  in  ADDR_WIDTH+1  tile length in words.
- busy_o  out  1  high outside IDLE.
- done_o  out  1  one-cycle pulse at tile completion.
- err_o  out  1  one-cycle pulse on a rejected start or a dropped request.
- acc_valid_i  in  1  accumulate request valid.
- acc_ready_o  out  1  accumulate request ready.
- acc_offset_i  in  ADDR_WIDTH  word offset within the tile.
- acc_data_i  in  DATA_WIDTH  addend.
- acc_last_i  in  1  marks the final request of the tile.
- buf_wr_en_o, buf_wr_addr_o, buf_wr_data_o  out  1/ADDR_WIDTH/DATA_WIDTH  buffer write port.
- buf_rmw_en_o, buf_rmw_addr_o, buf_rmw_data_o  out  1/ADDR_WIDTH/DATA_WIDTH  buffer RMW port.
- buf_wide_rd_en_o, buf_wide_rd_addr_o  out  1/ADDR_WIDTH  buffer wide-read request.
- buf_wide_rd_data_i  in  NUM_LANES*DATA_WIDTH  buffer wide-read data (combinational).
- out_valid_o, out_ready_i  out/in  1/1  drain handshake.
- out_data_o  out  NUM_LANES*DATA_WIDTH  drain beat; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_last_o  out  1  final drain beat.

Behaviour:
- States: IDLE, CLEAR, ACCUM, DRAIN.
- Reset: state IDLE, counters 0, every output 0. No buffer enables are asserted in any cycle with rst_i high. Reset mid-tile aborts with no done_o.
- IDLE, start_i=1: reject if tile_len_i==0, tile_len_i%NUM_LANES!=0, or base_addr_i+tile_len_i>DEPTH.
  - Reject: err_o pulses the next cycle; stay IDLE.
  - Accept: latch base and length, cnt=0, go to CLEAR.
- start_i is ignored outside IDLE.
- CLEAR: each cycle drive buf_wr_en_o=1, addr=base+cnt, data=0, then cnt++. After tile_len writes go to ACCUM. acc_ready_o=0 throughout.
- ACCUM:
  - acc_ready_o=1.
  - On each handshake, in the same cycle (combinational): buf_rmw_en_o=1, addr=base+acc_offset_i, data=acc_data_i.
  - Handshake with acc_offset_i>=tile_len: no RMW, err_o pulses next cycle; acc_last_i is still honoured.
  - Back-to-back handshakes to the same offset are legal; the buffer completes each RMW in one cycle.
  - acc_last_i handshake: go to DRAIN with ptr=0.
- DRAIN:
  - One-entry output register.
  - Issue buf_wide_rd_en_o=1, addr=base+ptr, whenever ptr<tile_len and (!out_valid_o or out_ready_i).
  - Issuing captures buf_wide_rd_data_i into out_data_o at the edge: out_valid_o=1 one cycle later, ptr+=NUM_LANES.
  - out_last_o=1 on the beat whose captured ptr==tile_len-NUM_LANES.
  - out_data_o, out_valid_o and out_last_o hold stable while out_valid_o && !out_ready_i.
  - Final beat accepted: done_o pulses the next cycle, state returns to IDLE, out_valid_o=0.
- Full throughput: one beat per cycle when out_ready_i is held high.
- busy_o is registered and high in CLEAR, ACCUM and DRAIN.

Optional Feature:
- Macro: ACCUM_TILE_CTRL_PERF_EN.
- Defined: adds outputs perf_acc_cnt_o (32 bits) and perf_stall_cnt_o (32 bits).
  - perf_acc_cnt_o counts accepted in-range accumulate handshakes.
  - perf_stall_cnt_o counts DRAIN cycles with out_valid_o && !out_ready_i.
  - Both clear on an accepted start and on reset, and saturate at all-ones.
- Undefined: the ports and counters are absent.

Test Plan:
- base=0x100, len=32, start -> 32 consecutive buf_wr_en_o cycles to 0x100..0x11F with data 0; acc_ready_o=1 on the following cycle.
- Issue 3 requests to offset 5 with data 1, 2, 3, last on the third -> 3 RMW cycles at 0x105; drain beat 0 lane 5 = 6, all other lanes = 0; 2 beats total, out_last_o on beat 1, done_o one cycle after.
- start with len=24, then with base=8180/len=32 -> err_o pulse each time, busy_o stays 0, no buffer enables asserted.
- Offset 40 with len=32 -> no RMW, err_o pulse; flow continues to DRAIN.
- During drain, hold out_ready_i=0 for 3 cycles -> out_data_o stable, no new read issued; with PERF_EN, perf_stall_cnt_o=3.
- rst_i during DRAIN -> IDLE next cycle, all outputs 0, no done_o; a following start runs normally.
